time_set_ctrl: RTL and testbench

Push-button time-setting controller for the digital alarm clock: the input-side counterpart of the display path. It synchronises and debounces three raw board buttons, runs a mode FSM (run / set hours / set minutes / commit), and edits a BCD copy of the time. It pauses the time counter while editing and emits a one-cycle load strobe with the edited HH:MM when the user exits set mode.

---
 rtl/time_set_ctrl.sv | 179 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Push-button time-setting controller: synchronises and debounces three buttons,
// walks RUN -> SET_HR -> SET_MIN -> COMMIT and edits a BCD HH:MM copy for the time counter.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [1:0] cur_hour_tens,
    input  logic [3:0] cur_hour_units,
    input  logic [2:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    output logic [1:0] set_hour_tens,
    output logic [3:0] set_hour_units,
    output logic [2:0] set_min_tens,
    output logic [3:0] set_min_units,
    output logic       load,
    output logic       clk_en,
    output logic [1:0] mode
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_SET_HR  = 2'b01,
        S_SET_MIN = 2'b10,
        S_COMMIT  = 2'b11
    } state_t;

    // Button vectors are ordered {mode, up, down}.
    logic [2:0]    w_btnRaw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_db;
    logic [2:0]    r_dbDly;
    logic [2:0]    r_press;
    logic [CW-1:0] r_cnt [3];

    state_t     r_state;
    state_t     w_stateNext;
    logic [5:0] r_hrSet;
    logic [6:0] r_minSet;
    logic [5:0] w_hrNext;
    logic [6:0] w_minNext;
    logic       r_load;
    logic       r_clkEn;

    logic w_pressMode;
    logic w_pressUp;
    logic w_pressDown;

    assign w_btnRaw    = {btn_mode, btn_up, btn_down};
    assign w_pressMode = r_press[2];
    assign w_pressUp   = r_press[1];
    assign w_pressDown = r_press[0];

    // A level is accepted only after the synchronised value differs from the
    // debounced one for DEBOUNCE_CYCLES consecutive clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_dbDly <= '0;
            r_press <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btnRaw;
            r_sync2 <= r_sync1;
            r_dbDly <= r_db;
            r_press <= r_db & ~r_dbDly;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    function automatic logic [5:0] hourInc(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd2 && u == 4'd3) return 6'd0;
        else if (u == 4'd9)         return {t + 2'd1, 4'd0};
        else                        return {t, u + 4'd1};
    endfunction

    function automatic logic [5:0] hourDec(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd0 && u == 4'd0) return {2'd2, 4'd3};
        else if (u == 4'd0)         return {t - 2'd1, 4'd9};
        else                        return {t, u - 4'd1};
    endfunction

    function automatic logic [6:0] minInc(input logic [2:0] t, input logic [3:0] u);
        if (t == 3'd5 && u == 4'd9) return 7'd0;
        else if (u == 4'd9)         return {t + 3'd1, 4'd0};
        else                        return {t, u + 4'd1};
    endfunction

    function automatic logic [6:0] minDec(input logic [2:0] t, input logic [3:0] u);
        if (t == 3'd0 && u == 4'd0) return {3'd5, 4'd9};
        else if (u == 4'd0)         return {t - 3'd1, 4'd9};
        else                        return {t, u - 4'd1};
    endfunction

    // Mode press always takes priority over up/down; up and down together cancel.
    always_comb begin
        w_stateNext = r_state;
        w_hrNext    = r_hrSet;
        w_minNext   = r_minSet;
        case (r_state)
            S_RUN: begin
                if (w_pressMode) begin
                    w_stateNext = S_SET_HR;
                    w_hrNext    = {cur_hour_tens, cur_hour_units};
                    w_minNext   = {cur_min_tens, cur_min_units};
                end
            end
            S_SET_HR: begin
                if (w_pressMode) begin
                    w_stateNext = S_SET_MIN;
                end else if (w_pressUp && !w_pressDown) begin
                    w_hrNext = hourInc(r_hrSet[5:4], r_hrSet[3:0]);
                end else if (w_pressDown && !w_pressUp) begin
                    w_hrNext = hourDec(r_hrSet[5:4], r_hrSet[3:0]);
                end
            end
            S_SET_MIN: begin
                if (w_pressMode) begin
                    w_stateNext = S_COMMIT;
                end else if (w_pressUp && !w_pressDown) begin
                    w_minNext = minInc(r_minSet[6:4], r_minSet[3:0]);
                end else if (w_pressDown && !w_pressUp) begin
                    w_minNext = minDec(r_minSet[6:4], r_minSet[3:0]);
                end
            end
            S_COMMIT: begin
                w_stateNext = S_RUN;
            end
            default: begin
                w_stateNext = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_RUN;
            r_hrSet  <= '0;
            r_minSet <= '0;
            r_load   <= 1'b0;
            r_clkEn  <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_hrSet  <= w_hrNext;
            r_minSet <= w_minNext;
            r_load   <= (w_stateNext == S_COMMIT);
            r_clkEn  <= (w_stateNext == S_RUN);
        end
    end

    assign set_hour_tens  = r_hrSet[5:4];
    assign set_hour_units = r_hrSet[3:0];
    assign set_min_tens   = r_minSet[6:4];
    assign set_min_units  = r_minSet[3:0];
    assign load           = r_load;
    assign clk_en         = r_clkEn;
    assign mode           = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a short debounce window; expected
// values are hand-computed BCD times and mode codes.
module tb_time_set_ctrl;

    localparam int DB = 4;
    localparam logic [2:0] B_MODE = 3'b100;
    localparam logic [2:0] B_UP   = 3'b010;
    localparam logic [2:0] B_DOWN = 3'b001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] cur_hour_tens = '0;
    logic [3:0] cur_hour_units = '0;
    logic [2:0] cur_min_tens = '0;
    logic [3:0] cur_min_units = '0;
    logic [1:0] set_hour_tens;
    logic [3:0] set_hour_units;
    logic [2:0] set_min_tens;
    logic [3:0] set_min_units;
    logic       load;
    logic       clk_en;
    logic [1:0] mode;

    int          vecCount = 0;
    int          missCount = 0;
    int          loadCount = 0;
    int          lc0;
    logic [12:0] loadSnap = '0;
    logic [1:0]  snapMode = '0;
    logic        snapClkEn = 1'b1;
    logic [12:0] setNow;

    time_set_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_mode       (btn_mode),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .cur_hour_tens  (cur_hour_tens),
        .cur_hour_units (cur_hour_units),
        .cur_min_tens   (cur_min_tens),
        .cur_min_units  (cur_min_units),
        .set_hour_tens  (set_hour_tens),
        .set_hour_units (set_hour_units),
        .set_min_tens   (set_min_tens),
        .set_min_units  (set_min_units),
        .load           (load),
        .clk_en         (clk_en),
        .mode           (mode)
    );

    always #5 clk = ~clk;

    assign setNow = {set_hour_tens, set_hour_units, set_min_tens, set_min_units};

    always @(negedge clk) begin
        if (load) begin
            loadCount = loadCount + 1;
            loadSnap  = setNow;
            snapMode  = mode;
            snapClkEn = clk_en;
        end
    end

    function automatic logic [12:0] packTime(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount = vecCount + 1;
        if (obs !== exp) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setCur(input int h, input int m);
        {cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units} = packTime(h, m);
    endtask

    task automatic applyStimulus(input logic [2:0] btns, input int hold);
        @(negedge clk);
        {btn_mode, btn_up, btn_down} = btns;
        repeat (hold) @(negedge clk);
        {btn_mode, btn_up, btn_down} = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        $display("[TB] start, DEBOUNCE_CYCLES=%0d", DB);

        // reset held while buttons chatter
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {btn_mode, btn_up, btn_down} = 3'(i);
        end
        {btn_mode, btn_up, btn_down} = 3'b000;
        #1;
        checkOutput("rst_mode", 32'(mode), 32'd0);
        checkOutput("rst_clk_en", 32'(clk_en), 32'd1);
        checkOutput("rst_load", 32'(load), 32'd0);
        checkOutput("rst_set", 32'(setNow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_mode", 32'(mode), 32'd0);
        checkOutput("idle_clk_en", 32'(clk_en), 32'd1);
        checkOutput("idle_set", 32'(setNow), 32'd0);
        checkOutput("idle_loads", 32'(loadCount), 32'd0);

        // full set sequence from 12:34
        setCur(12, 34);
        applyStimulus(B_MODE, 10);
        checkOutput("enter_mode", 32'(mode), 32'd1);
        checkOutput("enter_clk_en", 32'(clk_en), 32'd0);
        checkOutput("capture", 32'(setNow), 32'(packTime(12, 34)));

        for (int h = 1; h <= 3; h++) begin
            applyStimulus(B_UP, h);
            checkOutput("bounce_reject", 32'(setNow), 32'(packTime(12, 34)));
        end

        // press latency: pulse after edge k+6, hours change on edge k+7
        @(negedge clk);
        btn_up = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("latency_k6", 32'(setNow), 32'(packTime(12, 34)));
        @(posedge clk);
        #1;
        checkOutput("latency_k7", 32'(setNow), 32'(packTime(13, 34)));
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("hold_one_pulse", 32'(setNow), 32'(packTime(13, 34)));

        applyStimulus(B_UP, 10);
        checkOutput("hr_up2", 32'(setNow), 32'(packTime(14, 34)));
        applyStimulus(B_MODE, 10);
        checkOutput("to_setmin", 32'(mode), 32'd2);
        checkOutput("setmin_clk_en", 32'(clk_en), 32'd0);
        applyStimulus(B_DOWN, 10);
        checkOutput("min_down1", 32'(setNow), 32'(packTime(14, 33)));
        for (int i = 0; i < 4; i++) applyStimulus(B_DOWN, 10);
        checkOutput("min_down5", 32'(setNow), 32'(packTime(14, 29)));

        lc0 = loadCount;
        applyStimulus(B_MODE, 10);
        checkOutput("load_once", 32'(loadCount - lc0), 32'd1);
        checkOutput("load_value", 32'(loadSnap), 32'(packTime(14, 29)));
        checkOutput("load_mode", 32'(snapMode), 32'd3);
        checkOutput("load_clk_en", 32'(snapClkEn), 32'd0);
        checkOutput("back_run", 32'(mode), 32'd0);
        checkOutput("run_clk_en", 32'(clk_en), 32'd1);

        setCur(8, 0);
        applyStimulus(B_UP, 10);
        checkOutput("run_hold_set", 32'(setNow), 32'(packTime(14, 29)));
        checkOutput("run_up_ignored", 32'(mode), 32'd0);

        // wrap-around at field limits
        setCur(23, 59);
        applyStimulus(B_MODE, 10);
        applyStimulus(B_UP, 10);
        checkOutput("hr_23_up", 32'(setNow), 32'(packTime(0, 59)));
        applyStimulus(B_DOWN, 10);
        checkOutput("hr_00_down", 32'(setNow), 32'(packTime(23, 59)));
        applyStimulus(B_MODE, 10);
        applyStimulus(B_UP, 10);
        checkOutput("min_59_up", 32'(setNow), 32'(packTime(23, 0)));
        applyStimulus(B_DOWN, 10);
        checkOutput("min_00_down", 32'(setNow), 32'(packTime(23, 59)));
        applyStimulus(B_MODE, 10);
        checkOutput("wrap_load", 32'(loadSnap), 32'(packTime(23, 59)));

        setCur(19, 9);
        applyStimulus(B_MODE, 10);
        applyStimulus(B_UP, 10);
        checkOutput("hr_19_up", 32'(setNow), 32'(packTime(20, 9)));
        applyStimulus(B_DOWN, 10);
        checkOutput("hr_20_down", 32'(setNow), 32'(packTime(19, 9)));
        applyStimulus(B_MODE, 10);
        applyStimulus(B_UP, 10);
        checkOutput("min_09_up", 32'(setNow), 32'(packTime(19, 10)));
        applyStimulus(B_DOWN, 10);
        checkOutput("min_10_down", 32'(setNow), 32'(packTime(19, 9)));
        applyStimulus(B_MODE, 10);

        setCur(0, 20);
        applyStimulus(B_MODE, 10);
        applyStimulus(B_MODE, 10);
        applyStimulus(B_DOWN, 10);
        checkOutput("min_20_down", 32'(setNow), 32'(packTime(0, 19)));
        applyStimulus(B_MODE, 10);

        // simultaneous presses
        setCur(7, 45);
        applyStimulus(B_MODE, 10);
        applyStimulus(B_UP | B_DOWN, 10);
        checkOutput("updown_cancel", 32'(setNow), 32'(packTime(7, 45)));
        checkOutput("updown_mode", 32'(mode), 32'd1);
        applyStimulus(B_MODE | B_UP, 10);
        checkOutput("modeup_mode", 32'(mode), 32'd2);
        checkOutput("modeup_hours", 32'(setNow), 32'(packTime(7, 45)));

        // reset while editing discards the edit
        applyStimulus(B_DOWN, 10);
        checkOutput("pre_reset_edit", 32'(setNow), 32'(packTime(7, 44)));
        lc0 = loadCount;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_mode", 32'(mode), 32'd0);
        checkOutput("midrst_clk_en", 32'(clk_en), 32'd1);
        checkOutput("midrst_set", 32'(setNow), 32'd0);
        checkOutput("midrst_load", 32'(load), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_load", 32'(loadCount - lc0), 32'd0);
        checkOutput("midrst_stay_run", 32'(mode), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
